// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares the single-port, synchronous-read instruction RAM between the Ifetc32
// fetch path (run mode) and the uart_bmpg program loader (load mode). It also
// sequences the hand-over: stall the PC, let the outstanding read drain, grant
// the loader, then release the CPU so it restarts from PC 0.
//
// Ports
//   clock        system clock, all state changes on posedge
//   reset        asynchronous, active-low reset
//   load_mode    switch level; 1 requests load mode
//   fetch_req    Ifetc32 fetch request
//   fetch_addr   byte PC from Ifetc32
//   fetch_instr  returned instruction (holds when fetch_valid=0)
//   fetch_valid  fetch_instr valid this cycle
//   fetch_err    one-cycle pulse for a misaligned / out-of-range fetch
//   pc_stall     Ifetc32 must hold its PC
//   cpu_hold     holds the rest of the CPU in reset
//   upg_wen      loader write strobe (one cycle per word)
//   upg_addr     loader word address
//   upg_data     loader write data
//   upg_done     loader finished pulse
//   mem_en       RAM enable
//   mem_we       RAM write enable
//   mem_addr     RAM word address
//   mem_wdata    RAM write data
//   mem_rdata    RAM read data, valid one cycle after a read enable
//   load_count   words written by the last/current load, saturating
//   drop_err     sticky flag: a loader write arrived outside LOAD
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic              pc_stall,
  output logic              cpu_hold,
  input  logic              upg_wen,
  input  logic [ADDR_W-1:0] upg_addr,
  input  logic [31:0]       upg_data,
  input  logic              upg_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  load_count,
  output logic              drop_err
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_LOAD,
    ST_RELEASE
  } state_t;

  state_t             state_q;
  logic               pend_q;      // a read was issued last cycle
  logic [31:0]        instr_q;     // last delivered instruction
  logic               err_q;
  logic               pc_stall_q;
  logic               cpu_hold_q;
  logic [CNT_W-1:0]   count_q;
  logic               drop_q;
  logic               armed_q;     // load_mode has been low since the last load

  logic fetch_legal;
  logic run_issue;
  logic load_write;

  // Word aligned and inside the 2^ADDR_W word window.
  assign fetch_legal = fetch_req && (fetch_addr[1:0] == 2'b00)
                       && (fetch_addr[31:ADDR_W+2] == '0);

  // Gated by reset so nothing reaches the RAM while reset is held.
  assign run_issue  = reset && (state_q == ST_RUN) && fetch_legal;
  assign load_write = reset && (state_q == ST_LOAD) && upg_wen;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (run_issue) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr[ADDR_W+1:2];
    end else if (load_write) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = upg_addr;
      mem_wdata = upg_data;
    end
  end

  // The RAM already adds one cycle of latency, so the returned word is passed
  // straight through in the cycle it arrives and captured for the hold case.
  assign fetch_instr = pend_q ? mem_rdata : instr_q;
  assign fetch_valid = pend_q;
  assign fetch_err   = err_q;
  assign pc_stall    = pc_stall_q;
  assign cpu_hold    = cpu_hold_q;
  assign load_count  = count_q;
  assign drop_err    = drop_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      pend_q     <= 1'b0;
      instr_q    <= '0;
      err_q      <= 1'b0;
      pc_stall_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      pend_q <= run_issue;
      if (pend_q) begin
        instr_q <= mem_rdata;
      end
      err_q <= (state_q == ST_RUN) && fetch_req && !fetch_legal;

      if (upg_wen && (state_q != ST_LOAD)) begin
        drop_q <= 1'b1;
      end

      if (!load_mode) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          if (load_mode && armed_q) begin
            state_q    <= ST_DRAIN;
            pc_stall_q <= 1'b1;
            armed_q    <= 1'b0;
          end
        end
        ST_DRAIN: begin
          state_q    <= ST_LOAD;
          cpu_hold_q <= 1'b1;
          count_q    <= '0;
        end
        ST_LOAD: begin
          // A write coincident with the exit condition is still counted.
          if (upg_wen && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
          end
          if (upg_done || !load_mode) begin
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state_q    <= ST_RUN;
          pc_stall_q <= 1'b0;
          cpu_hold_q <= 1'b0;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Arbitrates the single-port instruction memory between the Ifetc32 fetch path (CPU run mode) and the UART program loader (load mode).
- Sequences the hand-over between the two sources: stalls the PC, drains the outstanding read, grants the loader, then releases the CPU to restart at PC 0.
- Sits between Ifetc32, the program RAM (synchronous read) and the uart_bmpg loader.

Parameters:
- ADDR_W, 14, memory word-address width (16K words).
- CNT_W, 15, width of the loaded-word counter (ADDR_W+1).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- load_mode  in  1  level from board switch; 1 requests load mode; synchronous to clock.
- fetch_req  in  1  Ifetc32 requests an instruction this cycle.
- fetch_addr  in  32  byte PC from Ifetc32.
- fetch_instr  out  32  returned instruction word.
- fetch_valid  out  1  fetch_instr valid this cycle.
- fetch_err  out  1  one-cycle pulse: misaligned or out-of-range fetch.
- pc_stall  out  1  Ifetc32 must hold PC.
- cpu_hold  out  1  holds the rest of the CPU in reset.
- upg_wen  in  1  loader write strobe, one cycle per word.
- upg_addr  in  ADDR_W  loader word address.
- upg_data  in  32  loader write data.
- upg_done  in  1  loader finished, one-cycle pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid one cycle after mem_en with mem_we=0.
- load_count  out  CNT_W  words written in the last or current load, saturating.
- drop_err  out  1  sticky; a loader write arrived outside LOAD.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to RUN.
  - fetch_instr=0, fetch_valid=0, fetch_err=0, pc_stall=0, cpu_hold=0, load_count=0, drop_err=0.
  - Read-pending flag cleared.
  - Memory outputs are combinational from state; in RUN they carry no access while reset is asserted.
  - Reset asserted mid-load abandons the load; load_count=0.
- States: RUN, DRAIN, LOAD, RELEASE.
- RUN:
  - Legal access: fetch_req=1, fetch_addr[1:0]=0 and fetch_addr[31:ADDR_W+2]=0.
  - On a legal access: mem_en=1, mem_we=0, mem_addr=fetch_addr[ADDR_W+1:2]; pending flag set.
  - Next cycle: fetch_valid=1, fetch_instr=mem_rdata (1-cycle latency; back-to-back fetches give one word per cycle).
  - Illegal fetch_req: no memory access; fetch_err pulses the next cycle; fetch_valid=0.
  - fetch_instr holds its last value when fetch_valid=0.
  - load_mode=1: state goes to DRAIN and pc_stall=1 from that same edge. A fetch presented in that cycle is still issued.
- DRAIN (exactly 1 cycle):
  - No new accesses.
  - Any pending read completes with fetch_valid=1.
  - Next state is LOAD; load_count cleared to 0.
- LOAD:
  - pc_stall=1, cpu_hold=1; fetch_req ignored (no access, no fetch_err).
  - Each upg_wen=1: mem_en=1, mem_we=1, mem_addr=upg_addr, mem_wdata=upg_data, same cycle.
  - Each write increments load_count, saturating at 2^CNT_W-1.
  - upg_done=1 or load_mode=0: state goes to RELEASE.
  - upg_wen coincident with upg_done: the write is performed and counted.
- RELEASE (exactly 1 cycle):
  - pc_stall=1, cpu_hold=1; no memory access.
  - Next state is RUN; pc_stall and cpu_hold deassert.
  - Ifetc32 is reset by cpu_hold and resumes at PC 0.
  - If load_mode is still 1 in RUN (upg_done path), no re-entry until load_mode has been seen 0 (rearm flag).
- drop_err:
  - Set when upg_wen=1 in RUN, DRAIN or RELEASE; the write is discarded.
  - Cleared only by reset.
- Priority: reset over everything; in LOAD, writes over exit.

Test Plan:
- Release reset at 8 ns, fetch_req=1, PC 0,4,8 with mem words 0x20010005, 0x00000000, 0x08000000 -> fetch_valid=1 one cycle after each request, fetch_instr matches in order, pc_stall=0.
- fetch_addr=0x00000006, then 0x00010000 (ADDR_W=14) -> no mem_en, fetch_err pulses one cycle each, fetch_valid=0.
- load_mode=1 while a read of PC 0x0C is pending:
  - fetch_valid=1 for that word in DRAIN.
  - pc_stall=1 from the next edge.
  - cpu_hold=1 in LOAD.
- In LOAD, upg_wen on 3 cycles writing 0x00050007 to addresses 0, 1, 2, then upg_done -> mem_we pulses 3 times with matching addr/data, load_count=3, RELEASE for 1 cycle, then RUN with cpu_hold=0. While load_mode stays 1, no re-entry.
- upg_wen=1 in RUN -> no mem write, drop_err=1 and stays 1 until reset.
- reset=0 asserted asynchronously mid-LOAD after 2 writes -> all outputs at reset values immediately, state RUN, load_count=0.
